hamming_secded_stream: RTL and testbench

- Streaming, pipelined SECDED Hamming decoder, parametrised in data width; successor to the fixed 11-bit combinational encoder.
- Takes extended codewords (Hamming plus an overall parity bit), corrects single-bit errors and flags double-bit errors.
- Uses a valid/ready handshake and keeps saturating error counters.
- Sits on the receive side, after the link or memory that carries the encoded words.

---
 rtl/hamming_secded_stream.sv | 164 ++++++++++++++++
 tb/tb_hamming_secded_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_stream.sv
// Two-stage SECDED decoder: corrects single-bit errors and flags double-bit errors.
// Output appears 2 cycles after acceptance; a downstream stall holds both stages and drops in_ready.
module hamming_secded_stream #(
   parameter int DATA_W = 11,
   parameter int PAR_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W+PAR_W:0]   entrada,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [DATA_W-1:0]       saida,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err_single,
   output logic                    err_double,
   output logic [PAR_W-1:0]        syndrome,
   output logic [CNT_W-1:0]        cnt_single,
   output logic [CNT_W-1:0]        cnt_double,
   input  logic                    cnt_clear
);
   localparam int CW_W = DATA_W + PAR_W;

   function automatic int min_par(input int dw);
      int r;
      r = 0;
      for (int k = 1; k < 31; k++)
         if (r == 0 && (1 << k) >= dw + k + 1) r = k;
      return r;
   endfunction

   // Codeword index of data bit j: the j-th non-power-of-two Hamming position.
   function automatic int data_pos(input int j);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int p = 1; p <= CW_W; p++)
         if ((p & (p - 1)) != 0) begin
            if (cnt == j) res = p - 1;
            cnt++;
         end
      return res;
   endfunction

   generate
      if (DATA_W < 1 || PAR_W != min_par(DATA_W)) begin : g_bad_param
         $error("hamming_secded_stream: PAR_W does not match DATA_W");
      end
   endgenerate

   logic                  s1_vld_q;
   logic [CW_W-1:0]       s1_cw_q;
   logic [PAR_W-1:0]      s1_syn_q;
   logic                  s1_pa_q;
   logic                  out_vld_q;
   logic [DATA_W-1:0]     saida_q;
   logic                  err_single_q;
   logic                  err_double_q;
   logic [PAR_W-1:0]      syndrome_q;
   logic [CNT_W-1:0]      cnt_single_q;
   logic [CNT_W-1:0]      cnt_double_q;

   logic                  s2_adv;
   logic                  s1_adv;
   logic                  s2_load;
   logic [PAR_W-1:0]      syn_d;
   logic                  pa_d;
   logic [CW_W-1:0]       fixed_cw;
   logic [DATA_W-1:0]     data_d;
   logic                  single_d;
   logic                  double_d;
   logic [CNT_W-1:0]      cnt_single_d;
   logic [CNT_W-1:0]      cnt_double_d;

   assign s2_adv   = !out_vld_q || out_ready;
   assign s1_adv   = !s1_vld_q || s2_adv;
   assign s2_load  = s2_adv && s1_vld_q;
   assign in_ready = s1_adv;

   always_comb begin
      syn_d = '0;
      for (int k = 0; k < PAR_W; k++)
         for (int i = 0; i < CW_W; i++)
            if ((((i + 1) >> k) & 1) == 1) syn_d[k] = syn_d[k] ^ entrada[i];
      pa_d = ^entrada;
   end

   always_comb begin
      fixed_cw = s1_cw_q;
      single_d = 1'b0;
      double_d = 1'b0;
      if (s1_syn_q == '0) begin
         single_d = s1_pa_q;
      end else if (s1_pa_q && int'(s1_syn_q) <= CW_W) begin
         single_d = 1'b1;
         for (int i = 0; i < CW_W; i++)
            if (int'(s1_syn_q) == i + 1) fixed_cw[i] = ~s1_cw_q[i];
      end else begin
         double_d = 1'b1;
      end
      data_d = '0;
      for (int j = 0; j < DATA_W; j++)
         data_d[j] = fixed_cw[data_pos(j)];
   end

   // Clear wins over a same-cycle increment; counts stick at all-ones.
   always_comb begin
      cnt_single_d = cnt_single_q;
      cnt_double_d = cnt_double_q;
      if (cnt_clear) begin
         cnt_single_d = '0;
         cnt_double_d = '0;
      end else if (s2_load) begin
         if (single_d && cnt_single_q != '1) cnt_single_d = cnt_single_q + CNT_W'(1);
         if (double_d && cnt_double_q != '1) cnt_double_d = cnt_double_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q     <= 1'b0;
         s1_cw_q      <= '0;
         s1_syn_q     <= '0;
         s1_pa_q      <= 1'b0;
         out_vld_q    <= 1'b0;
         saida_q      <= '0;
         err_single_q <= 1'b0;
         err_double_q <= 1'b0;
         syndrome_q   <= '0;
         cnt_single_q <= '0;
         cnt_double_q <= '0;
      end else begin
         if (s1_adv) begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
               s1_cw_q  <= entrada[CW_W-1:0];
               s1_syn_q <= syn_d;
               s1_pa_q  <= pa_d;
            end
         end
         if (s2_adv) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               saida_q      <= data_d;
               err_single_q <= single_d;
               err_double_q <= double_d;
               syndrome_q   <= s1_syn_q;
            end
         end
         cnt_single_q <= cnt_single_d;
         cnt_double_q <= cnt_double_d;
      end
   end

   assign out_valid  = out_vld_q;
   assign saida      = saida_q;
   assign err_single = err_single_q;
   assign err_double = err_double_q;
   assign syndrome   = syndrome_q;
   assign cnt_single = cnt_single_q;
   assign cnt_double = cnt_double_q;
endmodule

// File: tb/tb_hamming_secded_stream.sv
// Scoreboard bench: directed codewords, expected beats queued at issue, monitor compares on output handshake.
module tb_hamming_secded_stream;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] entrada;
   logic        in_valid;
   logic        out_ready;
   logic        cnt_clear;

   logic        in_ready, out_valid, err_single, err_double;
   logic [10:0] saida;
   logic [3:0]  syndrome;
   logic [15:0] cnt_single, cnt_double;

   logic        sat_in_ready, sat_out_valid, sat_err_single, sat_err_double;
   logic [10:0] sat_saida;
   logic [3:0]  sat_syndrome;
   logic [1:0]  sat_cnt_single, sat_cnt_double;

   typedef struct packed {
      logic [10:0] d;
      logic [3:0]  s;
      logic        es;
      logic        ed;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   logic saw_stall = 1'b0;

   always #5 clk = ~clk;

   hamming_secded_stream u_dut (
      .clk(clk), .rst(rst), .entrada(entrada), .in_valid(in_valid), .in_ready(in_ready),
      .saida(saida), .out_valid(out_valid), .out_ready(out_ready),
      .err_single(err_single), .err_double(err_double), .syndrome(syndrome),
      .cnt_single(cnt_single), .cnt_double(cnt_double), .cnt_clear(cnt_clear)
   );

   hamming_secded_stream #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .entrada(entrada), .in_valid(in_valid), .in_ready(sat_in_ready),
      .saida(sat_saida), .out_valid(sat_out_valid), .out_ready(out_ready),
      .err_single(sat_err_single), .err_double(sat_err_double), .syndrome(sat_syndrome),
      .cnt_single(sat_cnt_single), .cnt_double(sat_cnt_double), .cnt_clear(cnt_clear)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [15:0] cw, input logic [10:0] d, input logic [3:0] s,
                       input logic es, input logic ed);
      int t;
      t = 0;
      entrada  = cw;
      in_valid = 1'b1;
      exp_q.push_back({d, s, es, ed});
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         fails++;
         tests++;
         $display("FAIL accept_timeout: in_ready still 0 for word %0h", cw);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || out_valid) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0 || out_valid) begin
         fails++;
         tests++;
         $display("FAIL drain_timeout: %0d beats still expected, out_valid=%0b", exp_q.size(), out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare on each output handshake and check held outputs stay stable.
   initial begin
      exp_t        e;
      logic        hold;
      logic [10:0] hold_d;
      logic [5:0]  hold_f;
      hold = 1'b0;
      hold_d = '0;
      hold_f = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
         end else begin
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (hold && out_valid) begin
               chk("stable_saida", saida, hold_d);
               chk("stable_status", {syndrome, err_single, err_double}, hold_f);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  fails++;
                  tests++;
                  $display("FAIL unexpected_beat: got saida=%0h with nothing expected", saida);
               end else begin
                  e = exp_q.pop_front();
                  chk("saida", saida, e.d);
                  chk("syndrome", syndrome, e.s);
                  chk("flags", {err_single, err_double}, {e.es, e.ed});
                  chk("sat_beat", {sat_out_valid, sat_saida, sat_syndrome, sat_err_single, sat_err_double},
                      {1'b1, e.d, e.s, e.es, e.ed});
               end
            end
            hold   = out_valid && !out_ready;
            hold_d = saida;
            hold_f = {syndrome, err_single, err_double};
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; entrada = '0; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outputs", {saida, syndrome, err_single, err_double}, 0);
      chk("rst_counters", {cnt_single, cnt_double}, 0);
      chk("rst_in_ready", {in_ready, sat_in_ready}, 2'b11);

      // Clean beat with latency check
      send(16'h8007, 11'h001, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("latency_cycle1", out_valid, 0);
      @(negedge clk);
      chk("latency_cycle2", out_valid, 1);
      wait_idle();
      chk("clean_counters", {cnt_single, cnt_double}, 0);

      send(16'h8003, 11'h001, 4'd3, 1'b1, 1'b0);
      wait_idle();
      chk("single_cnt", cnt_single, 1);

      send(16'h0007, 11'h001, 4'd0, 1'b1, 1'b0);
      send(16'h8004, 11'h001, 4'd3, 1'b0, 1'b1);
      wait_idle();
      chk("cnt_single_2", cnt_single, 2);
      chk("cnt_double_1", cnt_double, 1);

      // Backpressure: five words back to back, out_ready low for three cycles
      saw_stall = 1'b0;
      fork
         begin
            send(16'h0000, 11'h000, 4'd0, 1'b0, 1'b0);
            send(16'hFFFF, 11'h7FF, 4'd0, 1'b0, 1'b0);
            send(16'hC08B, 11'h400, 4'd0, 1'b0, 1'b0);
            send(16'h8019, 11'h002, 4'd0, 1'b0, 1'b0);
            send(16'hFF7F, 11'h7FF, 4'd8, 1'b1, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_idle();
      chk("bp_in_ready_fell", saw_stall, 1);
      chk("bp_cnt_single", cnt_single, 3);
      chk("bp_sat_single", sat_cnt_single, 3);

      // Highest position correction and saturation of the 2-bit counters
      send(16'h808B, 11'h400, 4'd15, 1'b1, 1'b0);
      send(16'h808B, 11'h400, 4'd15, 1'b1, 1'b0);
      wait_idle();
      chk("cnt_single_5", cnt_single, 5);
      chk("sat_single_held", sat_cnt_single, 3);
      chk("sat_double", sat_cnt_double, 1);

      // Clear in the same cycle as a flagged beat's S2 load
      send(16'h0003, 11'h000, 4'd3, 1'b0, 1'b1);
      cnt_clear = 1'b1;
      @(posedge clk);
      #1 cnt_clear = 1'b0;
      chk("clear_dut", {cnt_single, cnt_double}, 0);
      chk("clear_sat", {sat_cnt_single, sat_cnt_double}, 0);
      wait_idle();
      send(16'h8003, 11'h001, 4'd3, 1'b1, 1'b0);
      wait_idle();
      chk("post_clear_cnt", {cnt_single, cnt_double}, {16'd1, 16'd0});

      // Reset with both stages full
      out_ready = 1'b0;
      send(16'h8007, 11'h001, 4'd0, 1'b0, 1'b0);
      send(16'h0000, 11'h000, 4'd0, 1'b0, 1'b0);
      chk("full_in_ready", in_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_counters", {cnt_single, cnt_double}, 0);
      out_ready = 1'b1;
      send(16'hFFFF, 11'h7FF, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("midrst_lat1", out_valid, 0);
      @(negedge clk);
      chk("midrst_lat2", out_valid, 1);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
